// File: rtl/tx_frame_arbiter.sv
// Frame-granular 2:1 arbiter in front of the TX interface read port.
// Port 0 (control) has priority; port 1 (data) is protected from starvation.
module tx_frame_arbiter #(
  parameter int unsigned IFG_CYCLES = 4,
  parameter int unsigned MAX_P0_RUN = 3,
  parameter int unsigned GAP_W      = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_p0_val,
  input  logic        i_p0_sof,
  input  logic        i_p0_eof,
  input  logic [7:0]  i_p0_data,
  input  logic [14:0] i_p0_frame_len,
  input  logic        i_p0_frame_len_val,
  output logic        o_p0_ack,
  input  logic        i_p1_val,
  input  logic        i_p1_sof,
  input  logic        i_p1_eof,
  input  logic [7:0]  i_p1_data,
  input  logic [14:0] i_p1_frame_len,
  input  logic        i_p1_frame_len_val,
  output logic        o_p1_ack,
  output logic        o_ari_val,
  output logic        o_ari_sof,
  output logic        o_ari_eof,
  output logic [7:0]  o_ari_data,
  output logic [14:0] o_ari_frame_len,
  output logic        o_ari_frame_len_val,
  input  logic        i_ari_ack,
  output logic [1:0]  o_grant,
  output logic        o_len_err
);

  localparam int unsigned RUN_W = (MAX_P0_RUN > 0) ? $clog2(MAX_P0_RUN + 1) : 1;

  typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

  state_t            state_q, state_d;
  logic [GAP_W-1:0]  gap_q;
  logic [RUN_W-1:0]  p0_run;
  logic [14:0]       beat_cnt;
  logic [14:0]       len_q;
  logic              req0, req1, win1, xfer;
  logic [14:0]       eff_len;
  logic [15:0]       beat_inc;

  assign req0 = i_p0_val & i_p0_sof & i_p0_frame_len_val;
  assign req1 = i_p1_val & i_p1_sof & i_p1_frame_len_val;
  assign win1 = req1 & (~req0 | (p0_run == RUN_W'(MAX_P0_RUN)));
  assign xfer = o_ari_val & i_ari_ack;

  // A single-beat frame carries sof and eof together, so its length is not latched yet.
  assign eff_len  = o_ari_sof ? o_ari_frame_len : len_q;
  assign beat_inc = {1'b0, beat_cnt} + 16'd1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (req0 | req1) state_d = XFER;
      XFER: if (xfer & o_ari_eof) state_d = (IFG_CYCLES > 0) ? GAP : IDLE;
      GAP:  if (gap_q == GAP_W'(IFG_CYCLES - 1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_ari_val           = 1'b0;
    o_ari_sof           = 1'b0;
    o_ari_eof           = 1'b0;
    o_ari_data          = '0;
    o_ari_frame_len     = '0;
    o_ari_frame_len_val = 1'b0;
    if (o_grant[0]) begin
      o_ari_val           = i_p0_val;
      o_ari_sof           = i_p0_sof;
      o_ari_eof           = i_p0_eof;
      o_ari_data          = i_p0_data;
      o_ari_frame_len     = i_p0_frame_len;
      o_ari_frame_len_val = i_p0_frame_len_val;
    end else if (o_grant[1]) begin
      o_ari_val           = i_p1_val;
      o_ari_sof           = i_p1_sof;
      o_ari_eof           = i_p1_eof;
      o_ari_data          = i_p1_data;
      o_ari_frame_len     = i_p1_frame_len;
      o_ari_frame_len_val = i_p1_frame_len_val;
    end
    o_p0_ack = o_grant[0] & i_ari_ack & i_p0_val;
    o_p1_ack = o_grant[1] & i_ari_ack & i_p1_val;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_grant   <= '0;
      o_len_err <= 1'b0;
      gap_q     <= '0;
      p0_run    <= '0;
      beat_cnt  <= '0;
      len_q     <= '0;
    end else begin
      o_len_err <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req0 | req1) begin
            o_grant  <= win1 ? 2'b10 : 2'b01;
            beat_cnt <= '0;
            if (win1 || !req1)
              p0_run <= '0;
            else if (p0_run != RUN_W'(MAX_P0_RUN))
              p0_run <= p0_run + RUN_W'(1);
          end
        end
        XFER: begin
          if (xfer) begin
            if (beat_cnt != '1) beat_cnt <= beat_cnt + 15'd1;
            if (o_ari_sof) len_q <= o_ari_frame_len;
            if (o_ari_eof) begin
              o_grant   <= '0;
              gap_q     <= '0;
              o_len_err <= (beat_inc != {1'b0, eff_len});
            end
          end
        end
        GAP: gap_q <= gap_q + GAP_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Directed bench for tx_frame_arbiter: frame sources per port, a frame-level
// reference model checked every cycle, and literal checks on key scenarios.
module tb_tx_frame_arbiter;

  localparam int IFG = 4;
  localparam int MAXR = 3;

  logic        i_clk, i_rst_n;
  logic        i_p0_val, i_p0_sof, i_p0_eof, i_p0_frame_len_val;
  logic [7:0]  i_p0_data;
  logic [14:0] i_p0_frame_len;
  logic        i_p1_val, i_p1_sof, i_p1_eof, i_p1_frame_len_val;
  logic [7:0]  i_p1_data;
  logic [14:0] i_p1_frame_len;
  logic        o_p0_ack, o_p1_ack;
  logic        o_ari_val, o_ari_sof, o_ari_eof, o_ari_frame_len_val;
  logic [7:0]  o_ari_data;
  logic [14:0] o_ari_frame_len;
  logic        i_ari_ack;
  logic [1:0]  o_grant;
  logic        o_len_err;

  tx_frame_arbiter #(.IFG_CYCLES(IFG), .MAX_P0_RUN(MAXR), .GAP_W(8)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_p0_val(i_p0_val), .i_p0_sof(i_p0_sof), .i_p0_eof(i_p0_eof),
    .i_p0_data(i_p0_data), .i_p0_frame_len(i_p0_frame_len),
    .i_p0_frame_len_val(i_p0_frame_len_val), .o_p0_ack(o_p0_ack),
    .i_p1_val(i_p1_val), .i_p1_sof(i_p1_sof), .i_p1_eof(i_p1_eof),
    .i_p1_data(i_p1_data), .i_p1_frame_len(i_p1_frame_len),
    .i_p1_frame_len_val(i_p1_frame_len_val), .o_p1_ack(o_p1_ack),
    .o_ari_val(o_ari_val), .o_ari_sof(o_ari_sof), .o_ari_eof(o_ari_eof),
    .o_ari_data(o_ari_data), .o_ari_frame_len(o_ari_frame_len),
    .o_ari_frame_len_val(o_ari_frame_len_val), .i_ari_ack(i_ari_ack),
    .o_grant(o_grant), .o_len_err(o_len_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {int len; int nb;} frame_t;
  frame_t q0[$], q1[$];
  int idx0, idx1;

  int checks, errors;
  int err_pulses;
  logic [1:0] glog[$];
  logic [1:0] prev_g;

  // Reference model: which port owns the link, gap remaining, beats seen.
  int m_grant, m_gap, m_beats, m_len, m_run;
  bit m_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_grant = -1; m_gap = 0; m_beats = 0; m_len = 0; m_run = 0; m_err = 0;
    prev_g = 2'b00;
  endtask

  task automatic drive();
    if (q0.size() > 0) begin
      i_p0_val = 1'b1; i_p0_sof = (idx0 == 0); i_p0_eof = (idx0 == q0[0].nb - 1);
      i_p0_data = 8'(8'h10 + idx0); i_p0_frame_len = 15'(q0[0].len); i_p0_frame_len_val = 1'b1;
    end else begin
      i_p0_val = 0; i_p0_sof = 0; i_p0_eof = 0; i_p0_data = '0; i_p0_frame_len = '0; i_p0_frame_len_val = 0;
    end
    if (q1.size() > 0) begin
      i_p1_val = 1'b1; i_p1_sof = (idx1 == 0); i_p1_eof = (idx1 == q1[0].nb - 1);
      i_p1_data = 8'(8'hA0 + idx1); i_p1_frame_len = 15'(q1[0].len); i_p1_frame_len_val = 1'b1;
    end else begin
      i_p1_val = 0; i_p1_sof = 0; i_p1_eof = 0; i_p1_data = '0; i_p1_frame_len = '0; i_p1_frame_len_val = 0;
    end
  endtask

  task automatic model_check();
    logic [1:0] eg;
    logic ev, es, ee, elv;
    logic [7:0] ed;
    logic [14:0] el;
    bit r0, r1, nerr;
    eg = (m_grant == 0) ? 2'b01 : (m_grant == 1) ? 2'b10 : 2'b00;
    {ev, es, ee, ed, el, elv} = '0;
    if (m_grant == 0) {ev, es, ee, ed, el, elv} = {i_p0_val, i_p0_sof, i_p0_eof, i_p0_data, i_p0_frame_len, i_p0_frame_len_val};
    if (m_grant == 1) {ev, es, ee, ed, el, elv} = {i_p1_val, i_p1_sof, i_p1_eof, i_p1_data, i_p1_frame_len, i_p1_frame_len_val};
    chk("grant", 32'(o_grant), 32'(eg));
    chk("ari_val", 32'(o_ari_val), 32'(ev));
    chk("ari_sof", 32'(o_ari_sof), 32'(es));
    chk("ari_eof", 32'(o_ari_eof), 32'(ee));
    chk("ari_data", 32'(o_ari_data), 32'(ed));
    chk("ari_len", 32'(o_ari_frame_len), 32'(el));
    chk("ari_len_val", 32'(o_ari_frame_len_val), 32'(elv));
    chk("p0_ack", 32'(o_p0_ack), 32'((m_grant == 0) && i_ari_ack && i_p0_val));
    chk("p1_ack", 32'(o_p1_ack), 32'((m_grant == 1) && i_ari_ack && i_p1_val));
    chk("len_err", 32'(o_len_err), 32'(m_err));
    if (o_len_err) err_pulses++;
    nerr = 0;
    if (m_grant >= 0) begin
      if (ev && i_ari_ack) begin
        if (es) m_len = int'(el);
        if (ee) begin
          if (m_beats + 1 != m_len) nerr = 1;
          m_grant = -1;
          m_gap = IFG;
        end
        m_beats = (m_beats + 1 > 32767) ? 32767 : m_beats + 1;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else begin
      r0 = i_p0_val && i_p0_sof && i_p0_frame_len_val;
      r1 = i_p1_val && i_p1_sof && i_p1_frame_len_val;
      if (r1 && (!r0 || m_run == MAXR)) begin
        m_grant = 1; m_run = 0; m_beats = 0;
      end else if (r0) begin
        m_grant = 0; m_beats = 0;
        m_run = r1 ? ((m_run < MAXR) ? m_run + 1 : MAXR) : 0;
      end
    end
    m_err = nerr;
  endtask

  task automatic step();
    logic a0, a1;
    @(negedge i_clk);
    model_check();
    a0 = o_p0_ack; a1 = o_p1_ack;
    @(posedge i_clk); #1;
    if (a0) begin idx0++; if (idx0 == q0[0].nb) begin void'(q0.pop_front()); idx0 = 0; end end
    if (a1) begin idx1++; if (idx1 == q1[0].nb) begin void'(q1.pop_front()); idx1 = 0; end end
    drive();
    if (o_grant != 2'b00 && prev_g == 2'b00) glog.push_back(o_grant);
    prev_g = o_grant;
  endtask

  task automatic run_idle(input string nm);
    int n;
    n = 0;
    while (!(q0.size() == 0 && q1.size() == 0 && m_grant < 0 && m_gap == 0) && n < 300) begin
      step(); n++;
    end
    step();
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL %s_timeout actual=%0d cycles required<300", nm, n);
    end
  endtask

  initial begin
    checks = 0; errors = 0; err_pulses = 0; idx0 = 0; idx1 = 0;
    i_rst_n = 1'b0; i_ari_ack = 1'b1;
    model_reset(); drive();
    @(posedge i_clk); @(posedge i_clk); #1;
    chk("rst_grant", 32'(o_grant), 0);
    chk("rst_ari_val", 32'(o_ari_val), 0);
    chk("rst_len_err", 32'(o_len_err), 0);
    chk("rst_acks", 32'({o_p1_ack, o_p0_ack}), 0);
    i_rst_n = 1'b1;

    // T1: single p1 frame, then gap before a p0 frame may win
    q1.push_back('{3, 3}); drive();
    step(); chk("t1_grant", 32'(o_grant), 32'h2);
    repeat (3) step();
    chk("t1_grant_clear", 32'(o_grant), 0);
    q0.push_back('{2, 2}); drive();
    repeat (4) begin
      step();
      chk("t1_gap_grant", 32'(o_grant), 0);
      chk("t1_gap_val", 32'(o_ari_val), 0);
    end
    step(); chk("t1_after_gap", 32'(o_grant), 32'h1);
    run_idle("t1");
    chk("t1_no_err", 32'(err_pulses), 0);

    // T2: simultaneous requests
    glog.delete();
    q0.push_back('{2, 2}); q1.push_back('{3, 3}); drive();
    run_idle("t2");
    chk("t2_count", 32'(glog.size()), 2);
    if (glog.size() == 2) begin
      chk("t2_first", 32'(glog[0]), 32'h1);
      chk("t2_second", 32'(glog[1]), 32'h2);
    end

    // T3: starvation protection
    glog.delete();
    repeat (5) q0.push_back('{2, 2});
    repeat (2) q1.push_back('{2, 2});
    drive();
    run_idle("t3");
    chk("t3_count", 32'(glog.size()), 7);
    if (glog.size() == 7) begin
      chk("t3_g0", 32'(glog[0]), 32'h1);
      chk("t3_g1", 32'(glog[1]), 32'h1);
      chk("t3_g2", 32'(glog[2]), 32'h1);
      chk("t3_g3", 32'(glog[3]), 32'h2);
      chk("t3_g4", 32'(glog[4]), 32'h1);
    end

    // T4: length check
    err_pulses = 0;
    q0.push_back('{5, 4}); drive();
    run_idle("t4a");
    chk("t4_short_pulses", 32'(err_pulses), 1);
    err_pulses = 0;
    q0.push_back('{5, 5}); drive();
    run_idle("t4b");
    chk("t4_exact_pulses", 32'(err_pulses), 0);
    err_pulses = 0;
    q1.push_back('{1, 1}); drive();
    run_idle("t4c");
    chk("t4_single_beat", 32'(err_pulses), 0);

    // T5: backpressure mid-frame with a competing p0 sof
    err_pulses = 0;
    q1.push_back('{6, 6}); drive();
    repeat (3) step();
    i_ari_ack = 1'b0;
    q0.push_back('{2, 2}); drive();
    repeat (3) begin
      step();
      chk("t5_grant_held", 32'(o_grant), 32'h2);
      chk("t5_no_p0_ack", 32'(o_p0_ack), 0);
    end
    i_ari_ack = 1'b1;
    run_idle("t5");
    chk("t5_no_err", 32'(err_pulses), 0);

    // T6: asynchronous reset during byte 2 of a p1 frame
    q1.push_back('{4, 4}); drive();
    step(); step();
    chk("t6_pre_val", 32'(o_ari_val), 1);
    i_rst_n = 1'b0; #1;
    chk("t6_grant", 32'(o_grant), 0);
    chk("t6_val", 32'(o_ari_val), 0);
    chk("t6_data", 32'(o_ari_data), 0);
    chk("t6_len_val", 32'(o_ari_frame_len_val), 0);
    chk("t6_acks", 32'({o_p1_ack, o_p0_ack}), 0);
    chk("t6_len_err", 32'(o_len_err), 0);
    q1.delete(); idx1 = 0; model_reset();
    q0.push_back('{2, 2}); drive();
    #2 i_rst_n = 1'b1;
    step(); chk("t6_regrant", 32'(o_grant), 32'h1);
    run_idle("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
